// File: rtl/lsq_pkg.sv
// Shared load/store-queue definitions for the store-data buffer.
// Holds the default geometry and the store-data record layout.
// No logic; imported by the buffer top and its bank.
package lsq_pkg;

  localparam int LSW_DATA_WIDTH = 139;
  localparam int LSW_ADDR_WIDTH = 8;
  localparam int LSW_ENTRIES    = 240;

  // One store-data record: two 64-bit halves, a flag, byte enables and access size.
  typedef struct packed {
    logic [63:0] data_lo;
    logic [63:0] data_hi;
    logic        flag;
    logic [7:0]  bmask;
    logic [1:0]  size;
  } lsw_rec_t;

endpackage

// File: rtl/lsw_data_bank.sv
// One bank of the store-data array: async multi-port reads, ordered writes.
// Reads are combinational; writes land on the next rising edge.
// No backpressure; on a same-row collision the highest-numbered write port wins.
module lsw_data_bank
  import lsq_pkg::*;
#(
  parameter int DATA_WIDTH = LSW_DATA_WIDTH,
  parameter int ROW_BITS   = 7,
  parameter int ROWS       = 120,
  parameter int RD_PORTS   = 6,
  parameter int NWP        = 6
) (
  input  logic                         clk,
  input  logic [RD_PORTS*ROW_BITS-1:0] rd_row,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic [NWP-1:0]               wp_en,
  input  logic [NWP*ROW_BITS-1:0]      wp_row,
  input  logic [NWP*DATA_WIDTH-1:0]    wp_data
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

  // Apply write ports in index order so the last enabled port on a row takes effect.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NWP; p++) begin
      if (wp_en[p]) begin
        mem[wp_row[p*ROW_BITS +: ROW_BITS]] <= wp_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Asynchronous read of each port's row.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_row[i*ROW_BITS +: ROW_BITS]];
    end
  end

endmodule

// File: rtl/lsw_data_banked.sv
// Banked store-data buffer: per-entry data + written flag, write bypass, reset sweep.
// Reads combinational (optionally see same-cycle writes); writes/clears take effect next edge.
// No backpressure; writes and clears are silently ignored while the reset sweep runs.
module lsw_data_banked
  import lsq_pkg::*;
#(
  parameter int DATA_WIDTH = LSW_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSW_ADDR_WIDTH,
  parameter int BANK_BITS  = 1,
  parameter int ENTRIES    = LSW_ENTRIES,
  parameter int RD_PORTS   = 6,
  parameter int WR_PORTS   = 2,
  parameter int NEW_PORTS  = 3,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [RD_PORTS-1:0]              rd_ok,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0]   wr_data,
  input  logic [WR_PORTS-1:0]              wr_en,
  input  logic [NEW_PORTS*ADDR_WIDTH-1:0]  new_addr,
  input  logic [NEW_PORTS-1:0]             new_en,
  output logic                             init_busy
);

  localparam int NBANK = 2**BANK_BITS;
  localparam int ROWS  = ENTRIES / NBANK;
  localparam int RB    = ADDR_WIDTH - BANK_BITS;
  // Bank write ports: data writes, then clears, then the sweep (later wins).
  localparam int NWP   = WR_PORTS + NEW_PORTS + 1;
  localparam logic [ADDR_WIDTH:0] ENT_LIM  = (ADDR_WIDTH+1)'(ENTRIES);
  localparam logic [RB-1:0]       LAST_ROW = RB'(ROWS - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < ENT_LIM;
  endfunction

  logic [RB-1:0]                    sweep_row;
  logic [ENTRIES-1:0]               written;
  logic [WR_PORTS-1:0]              wr_ok;
  logic [NEW_PORTS-1:0]             new_ok;
  logic [RD_PORTS*RB-1:0]           rd_row;
  logic [RD_PORTS*DATA_WIDTH-1:0]   bank_rd [NBANK];
  logic [RD_PORTS-1:0]              byp_hit;
  logic [RD_PORTS-1:0]              clr_hit;
  logic [DATA_WIDTH-1:0]            byp_dat [RD_PORTS];

  // Sweep counter: zero one row of every bank per cycle until the last row is done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_busy <= 1'b1;
      sweep_row <= '0;
    end else if (init_busy) begin
      if (sweep_row == LAST_ROW) init_busy <= 1'b0;
      else                       sweep_row <= sweep_row + RB'(1);
    end
  end

  // Qualify writes and clears: dropped during the sweep and for unimplemented entries.
  always_comb begin
    wr_ok  = '0;
    new_ok = '0;
    for (int p = 0; p < WR_PORTS; p++)
      wr_ok[p] = wr_en[p] && !init_busy && in_range(wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
    for (int n = 0; n < NEW_PORTS; n++)
      new_ok[n] = new_en[n] && !init_busy && in_range(new_addr[n*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // Written flags: writes set, clears applied afterwards so a clear beats a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written <= '0;
    end else begin
      for (int p = 0; p < WR_PORTS; p++)
        if (wr_ok[p]) written[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
      for (int n = 0; n < NEW_PORTS; n++)
        if (new_ok[n]) written[new_addr[n*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
    end
  end

  // Every bank sees every read row; the bank select happens after the read.
  always_comb begin
    rd_row = '0;
    for (int i = 0; i < RD_PORTS; i++)
      rd_row[i*RB +: RB] = rd_addr[i*ADDR_WIDTH+BANK_BITS +: RB];
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [NWP-1:0]            wp_en;
    logic [NWP*RB-1:0]         wp_row;
    logic [NWP*DATA_WIDTH-1:0] wp_data;

    // Steer qualified writes/clears to this bank; clears and sweep carry zero data.
    always_comb begin
      wp_en   = '0;
      wp_row  = '0;
      wp_data = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        wp_en[p] = wr_ok[p] && (wr_addr[p*ADDR_WIDTH +: BANK_BITS] == BANK_BITS'(b));
        wp_row[p*RB +: RB] = wr_addr[p*ADDR_WIDTH+BANK_BITS +: RB];
        wp_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int n = 0; n < NEW_PORTS; n++) begin
        wp_en[WR_PORTS+n] = new_ok[n] && (new_addr[n*ADDR_WIDTH +: BANK_BITS] == BANK_BITS'(b));
        wp_row[(WR_PORTS+n)*RB +: RB] = new_addr[n*ADDR_WIDTH+BANK_BITS +: RB];
      end
      wp_en[NWP-1] = init_busy;
      wp_row[(NWP-1)*RB +: RB] = sweep_row;
    end

    lsw_data_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_BITS   (RB),
      .ROWS       (ROWS),
      .RD_PORTS   (RD_PORTS),
      .NWP        (NWP)
    ) u_bank (
      .clk     (clk),
      .rd_row  (rd_row),
      .rd_data (bank_rd[b]),
      .wp_en   (wp_en),
      .wp_row  (wp_row),
      .wp_data (wp_data)
    );
  end

  // Read select: highest-index same-cycle write bypasses unless a clear hits the entry.
  always_comb begin
    rd_data = '0;
    rd_ok   = '0;
    byp_hit = '0;
    clr_hit = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      byp_dat[i] = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
          byp_hit[i] = 1'b1;
          byp_dat[i] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int n = 0; n < NEW_PORTS; n++)
        if (new_en[n] && new_addr[n*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
          clr_hit[i] = 1'b1;
      if (!init_busy && in_range(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        if (BYPASS != 0 && byp_hit[i] && !clr_hit[i]) begin
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = byp_dat[i];
          rd_ok[i] = 1'b1;
        end else begin
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            bank_rd[rd_addr[i*ADDR_WIDTH +: BANK_BITS]][i*DATA_WIDTH +: DATA_WIDTH];
          rd_ok[i] = written[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsw_data_banked.sv
// Self-checking bench for lsw_data_banked (default parameters, BYPASS=1).
// Directed vector table, reset/sweep sequences, then randomized traffic vs. an entry-level model.
// Inputs driven just after the rising edge; outputs compared a few ns later.
module tb_lsw_data_banked;

  localparam int DW = 139, AW = 8, RD = 6, WR = 2, NW = 3, ENT = 240;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [RD*AW-1:0] rd_addr;
  logic [RD*DW-1:0] rd_data;
  logic [RD-1:0]    rd_ok;
  logic [WR*AW-1:0] wr_addr;
  logic [WR*DW-1:0] wr_data;
  logic [WR-1:0]    wr_en;
  logic [NW*AW-1:0] new_addr;
  logic [NW-1:0]    new_en;
  logic             init_busy;

  logic [AW-1:0] ra [RD];
  logic [AW-1:0] wa [WR];
  logic [DW-1:0] wd [WR];
  logic [AW-1:0] na [NW];
  logic [WR-1:0] we;
  logic [NW-1:0] ne;

  always_comb begin
    for (int i = 0; i < RD; i++) rd_addr[i*AW +: AW] = ra[i];
    for (int p = 0; p < WR; p++) begin
      wr_addr[p*AW +: AW] = wa[p];
      wr_data[p*DW +: DW] = wd[p];
    end
    for (int n = 0; n < NW; n++) new_addr[n*AW +: AW] = na[n];
    wr_en  = we;
    new_en = ne;
  end

  lsw_data_banked dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ok(rd_ok),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .new_addr(new_addr), .new_en(new_en), .init_busy(init_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < RD; i++) ra[i] = '0;
    for (int p = 0; p < WR; p++) begin wa[p] = '0; wd[p] = '0; end
    for (int n = 0; n < NW; n++) na[n] = '0;
    we = '0;
    ne = '0;
  endtask

  // Counts cycles with init_busy high starting right after reset release; expects 120.
  task automatic count_busy(input string nm);
    int n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      if (n == 5) begin
        #2;
        chk({nm, " rd_ok during sweep"}, DW'(rd_ok), '0);
        chk({nm, " rd_data during sweep"}, rd_data[DW-1:0], '0);
      end
      n++;
      tick();
    end
    chk({nm, " busy cycles"}, DW'(n), DW'(120));
  endtask

  typedef struct {
    logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
    logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    logic          n0e; logic [AW-1:0] n0a;
    logic [AW-1:0] rda; logic [DW-1:0] ed;  logic eo;
  } vec_t;

  function automatic vec_t mk(input logic w0e, input logic [7:0] w0a, input logic [31:0] w0d,
                              input logic w1e, input logic [7:0] w1a, input logic [31:0] w1d,
                              input logic n0e, input logic [7:0] n0a,
                              input logic [7:0] rda, input logic [31:0] ed, input logic eo);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = {107'b0, w0d};
    v.w1e = w1e; v.w1a = w1a; v.w1d = {107'b0, w1d};
    v.n0e = n0e; v.n0a = n0a; v.rda = rda;
    v.ed  = {107'b0, ed}; v.eo = eo;
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'($urandom_range(232, 255));
      default: return 8'($urandom_range(0, 11));
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  vec_t          tbl [18];
  logic [DW-1:0] m_dat [ENT];
  logic          m_ok  [ENT];
  logic [DW-1:0] ed, hd;
  logic          eo, hit, cl;

  initial begin
    idle();

    // Power-up: 3 cycles of reset, then the sweep with writes/clears that must be ignored.
    repeat (3) tick();
    rst = 1'b1;
    we[0] = 1'b1; wa[0] = 8'h77; wd[0] = {DW{1'b1}};
    ne[0] = 1'b1; na[0] = 8'h05;
    for (int i = 0; i < RD; i++) ra[i] = 8'h77;
    count_busy("sweep1");
    idle();

    tbl[0]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h00, 0,      0);
    tbl[1]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h77, 0,      0);
    tbl[2]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'hEF, 0,      0);
    tbl[3]  = mk(1, 8'h05, 'h1234, 0, 8'h00, 0,    0, 8'h00, 8'h04, 0,      0);
    tbl[4]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h05, 'h1234, 1);
    tbl[5]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h04, 0,      0);
    tbl[6]  = mk(1, 8'h10, 'hAA,   1, 8'h10, 'hBB, 1, 8'h10, 8'h10, 0,      0);
    tbl[7]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h10, 0,      0);
    tbl[8]  = mk(1, 8'h10, 'hAA,   1, 8'h10, 'hBB, 0, 8'h00, 8'h10, 'hBB,   1);
    tbl[9]  = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h10, 'hBB,   1);
    tbl[10] = mk(0, 8'h00, 0,      1, 8'h21, 'h55, 0, 8'h00, 8'h21, 'h55,   1);
    tbl[11] = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h21, 'h55,   1);
    tbl[12] = mk(1, 8'hF4, 'h99,   0, 8'h00, 0,    0, 8'h00, 8'hF4, 0,      0);
    tbl[13] = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'hF4, 0,      0);
    tbl[14] = mk(0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h05, 8'h05, 'h1234, 1);
    tbl[15] = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'h05, 0,      0);
    tbl[16] = mk(1, 8'hEF, 'h7,    0, 8'h00, 0,    0, 8'h00, 8'hEE, 0,      0);
    tbl[17] = mk(0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h00, 8'hEF, 'h7,    1);

    for (int k = 0; k < 18; k++) begin
      idle();
      we[0] = tbl[k].w0e; wa[0] = tbl[k].w0a; wd[0] = tbl[k].w0d;
      we[1] = tbl[k].w1e; wa[1] = tbl[k].w1a; wd[1] = tbl[k].w1d;
      ne[0] = tbl[k].n0e; na[0] = tbl[k].n0a;
      for (int i = 0; i < RD; i++) ra[i] = tbl[k].rda;
      #2;
      for (int i = 0; i < RD; i++) begin
        chk($sformatf("vec%0d rd%0d data", k, i), rd_data[i*DW +: DW], tbl[k].ed);
        chk($sformatf("vec%0d rd%0d ok", k, i), DW'(rd_ok[i]), DW'(tbl[k].eo));
      end
      tick();
    end
    idle();

    // Reset pulsed at sweep row 50 must restart the sweep from row 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (50) tick();
    chk("busy at row 50", DW'(init_busy), DW'(1));
    rst = 1'b0;
    tick();
    chk("busy in reset", DW'(init_busy), DW'(1));
    rst = 1'b1;
    count_busy("sweep restart");

    // Randomized traffic against an entry-level model.
    for (int a = 0; a < ENT; a++) begin m_dat[a] = '0; m_ok[a] = 1'b0; end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < RD; i++) ra[i] = rnd_addr();
      for (int p = 0; p < WR; p++) begin
        wa[p] = rnd_addr(); wd[p] = rnd_data(); we[p] = 1'($urandom_range(0, 1));
      end
      for (int n = 0; n < NW; n++) begin
        na[n] = rnd_addr(); ne[n] = ($urandom_range(0, 3) == 0);
      end
      #2;
      for (int i = 0; i < RD; i++) begin
        ed = '0; eo = 1'b0;
        if (ra[i] < ENT) begin
          hit = 1'b0; cl = 1'b0; hd = '0;
          for (int p = 0; p < WR; p++) if (we[p] && wa[p] == ra[i]) begin hit = 1'b1; hd = wd[p]; end
          for (int n = 0; n < NW; n++) if (ne[n] && na[n] == ra[i]) cl = 1'b1;
          if (hit && !cl) begin ed = hd; eo = 1'b1; end
          else begin ed = m_dat[ra[i]]; eo = m_ok[ra[i]]; end
        end
        chk($sformatf("rnd c%0d rd%0d a%02h data", c, i, ra[i]), rd_data[i*DW +: DW], ed);
        chk($sformatf("rnd c%0d rd%0d a%02h ok", c, i, ra[i]), DW'(rd_ok[i]), DW'(eo));
      end
      for (int p = 0; p < WR; p++)
        if (we[p] && wa[p] < ENT) begin m_dat[wa[p]] = wd[p]; m_ok[wa[p]] = 1'b1; end
      for (int n = 0; n < NW; n++)
        if (ne[n] && na[n] < ENT) begin m_dat[na[n]] = '0; m_ok[na[n]] = 1'b0; end
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
